wb_sram32: RTL and testbench
============================

Name: wb_sram32

Overview:
- Wishbone slave controller for the board's external asynchronous SRAM: two 256Kx16 devices in parallel, forming one 32-bit word-addressed array.
- Connects to interconnect slave 0 (region 0x4xxxxxxx); the interconnect feeds it decoded cycles from the lm32 instruction and data masters.
- Converts each single Wishbone classic cycle into a timed SRAM read or write with programmable wait states.
- Ends each access with a one-cycle bus-turnaround gap.

Parameters:
- adr_width, 18, SRAM word-address width; SRAM address = wb_adr_i[adr_width+1:2].
- latency, 2, wait cycles per access (asserted-strobe cycles); legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- wb_adr_i  in  32  byte address; bits [1:0] and bits above adr_width+1 are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_sel_i  in  4  byte lane enables; bit 3 = bits [31:24].
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge, one-cycle pulse, registered.
- sram_adr  out  adr_width  SRAM address, registered.
- sram_dat  inout  32  SRAM data bus; driven only during writes.
- sram_be_n  out  4  byte enables, active-low; bit 3 = upper byte of the upper device.
- sram_ce_n  out  1  chip enable for both devices, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- All outputs are registered. sram_dat tristate enable (drive_en) is a registered internal bit.

Reset (synchronous, takes effect at the next edge from any state; aborts any access mid-operation):
- state = IDLE, cnt = 0, wb_ack_o = 0, wb_dat_o = 0.
- sram_ce_n = sram_oe_n = sram_we_n = 1, sram_be_n = 4'hF, sram_adr = 0, drive_en = 0.

States: IDLE, RD, WR, END.

IDLE:
- All SRAM controls inactive; drive_en = 0.
- On wb_cyc_i & wb_stb_i, at the next edge:
  - latch sram_adr from the address slice and the write data register from wb_dat_i;
  - set cnt = latency-1 and sram_ce_n = 0;
  - read (wb_we_i = 0): go to RD with sram_oe_n = 0, sram_be_n = 4'h0;
  - write (wb_we_i = 1): go to WR with sram_we_n = 0, sram_be_n = ~wb_sel_i, drive_en = 1.

RD:
- Controls held; cnt decrements each cycle.
- At the edge where cnt == 0: wb_dat_o <= sram_dat, wb_ack_o <= 1, all controls inactive, go to END.

WR:
- Controls and data held; cnt decrements each cycle.
- At the edge where cnt == 0: sram_we_n <= 1, sram_ce_n <= 1, sram_be_n <= 4'hF, wb_ack_o <= 1, go to END.
- drive_en stays 1, giving data hold time after we_n rises.

END:
- wb_ack_o is high for exactly this one cycle.
- At the next edge: wb_ack_o <= 0, drive_en <= 0, go to IDLE.
- wb_stb_i is not sampled in END. A new request can be accepted no earlier than the IDLE cycle that follows.

Latency and timing:
- The request is sampled at edge 0. SRAM strobes are low for exactly latency cycles (cycles 1..latency).
- wb_ack_o is high in cycle latency+1, for reads and writes alike.
- Back-to-back requests: accesses are separated by at least one IDLE cycle with all controls high.

Data and address rules:
- wb_dat_o holds the last read value until the next read completes; writes do not change it.
- Writes with wb_sel_i = 0: the full cycle runs with sram_be_n = 4'hF and is acknowledged; memory is unchanged.
- Addresses beyond 2^adr_width words alias (upper bits dropped); there is no error response.

Cycle abandonment:
- If the master drops wb_cyc_i or wb_stb_i after acceptance, the access still completes and ack still pulses.
- wb_we_i, wb_sel_i, wb_adr_i and wb_dat_i are sampled only in IDLE; changes afterwards are ignored.

Test Plan:
- Reset: assert rst for 2 cycles during a write in WR. The next cycle shows all controls high, sram_dat at Z, ack 0 and IDLE; a subsequent read of that word does not hang.
- Write then read, latency=2: write 0xDEADBEEF to 0x40000010 with sel=F; sram_adr=4, we_n low for exactly 2 cycles, ack in cycle 3. Read of the same address returns 0xDEADBEEF, with oe_n low for 2 cycles and ack in cycle 3.
- Byte lanes: after the word is 0x11223344, write 0xAABBCCDD with sel=4'b0101 (sram_be_n=4'b1010). A read returns 0x11BB33DD.
- Back-to-back: hold stb through 3 consecutive reads of addresses 0, 4 and 8. Each gets exactly one ack, there is at least one cycle with ce_n=1 between accesses, and drive_en is never 1.
- Latency sweep: latency=1 gives ack in cycle 2; latency=15 gives strobes low for 15 cycles and ack in cycle 16.
- Aliasing and sel=0: a write to 0x40100000 (adr_width=18) lands at SRAM word 0. A sel=0 write leaves memory unchanged and is acknowledged in cycle latency+1.

Source files
------------

// File: rtl/wb_sram32.sv
// Wishbone classic slave for the external 32-bit asynchronous SRAM (two 256Kx16 parts).
// Each accepted cycle becomes one timed read or write, followed by a one-cycle turnaround gap.
module wb_sram32 #(
  parameter int adr_width = 18,
  parameter int latency   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] sram_adr,
  inout  wire  [31:0]          sram_dat,
  output logic [3:0]           sram_be_n,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic [31:0]          r_wdat;
  logic                 r_drive_en;
  logic                 w_req;
  logic [adr_width-1:0] w_adr;
  logic                 w_unused;

  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_adr    = wb_adr_i[adr_width+1:2];
  assign w_unused = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  // Data stays driven through the ack cycle of a write to give hold time after we_n rises.
  assign sram_dat = r_drive_en ? r_wdat : {32{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wdat     <= 32'd0;
      r_drive_en <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 32'd0;
      sram_adr   <= '0;
      sram_be_n  <= 4'hF;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_be_n  <= 4'hF;
          r_drive_en <= 1'b0;
          if (w_req) begin
            sram_adr  <= w_adr;
            r_wdat    <= wb_dat_i;
            r_cnt     <= 4'(latency - 1);
            sram_ce_n <= 1'b0;
            if (wb_we_i) begin
              r_state    <= S_WR;
              sram_we_n  <= 1'b0;
              sram_be_n  <= ~wb_sel_i;
              r_drive_en <= 1'b1;
            end else begin
              r_state   <= S_RD;
              sram_oe_n <= 1'b0;
              sram_be_n <= 4'h0;
            end
          end
        end
        S_RD: begin
          if (r_cnt == 4'd0) begin
            wb_dat_o  <= sram_dat;
            wb_ack_o  <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            r_state   <= S_END;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WR: begin
          if (r_cnt == 4'd0) begin
            wb_ack_o  <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            r_state   <= S_END;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          wb_ack_o   <= 1'b0;
          r_drive_en <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram32.sv
// Bench for wb_sram32: an SRAM device model on the bus, a transaction-level reference model
// compared every cycle, directed scenarios, a latency sweep on two extra instances, and random traffic.
module tb_wb_sram32;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stbMain, stbL1, stbL15, we;
  logic [31:0] wbAdr, wbDat;
  logic [3:0]  sel;

  logic [31:0] datOut;
  logic        ack;
  logic [17:0] sramAdr;
  wire  [31:0] sramDat;
  logic [3:0]  beN;
  logic        ceN, oeN, weN;

  logic [31:0] unusedDatOutL1, unusedDatOutL15;
  logic        ackL1, ackL15, ceL1, ceL15;
  logic [17:0] unusedAdrL1, unusedAdrL15;
  wire  [31:0] unusedSramL1, unusedSramL15;
  logic [3:0]  unusedBeL1, unusedBeL15;
  logic        unusedOeL1, unusedOeL15, unusedWeL1, unusedWeL15;

  int total = 0;
  int bad   = 0;

  bit [31:0] devMem [0:262143];
  bit [31:0] refMem [0:262143];

  // Reference model state: one accepted transaction and how many cycles have passed since acceptance.
  bit          mBusy = 1'b0;
  bit          mChkEn = 1'b0;
  int          mK = 0;
  bit          mWe;
  logic [3:0]  mSel;
  logic [17:0] mAdr;
  logic [31:0] mWdat;
  logic [31:0] mLastRead;

  always #5 clk = ~clk;

  wb_sram32 #(.adr_width(18), .latency(LAT)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wbAdr), .wb_dat_i(wbDat), .wb_dat_o(datOut),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stbMain), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .sram_adr(sramAdr), .sram_dat(sramDat), .sram_be_n(beN), .sram_ce_n(ceN),
    .sram_oe_n(oeN), .sram_we_n(weN)
  );

  wb_sram32 #(.adr_width(18), .latency(1)) dutL1 (
    .clk(clk), .rst(rst), .wb_adr_i(wbAdr), .wb_dat_i(wbDat), .wb_dat_o(unusedDatOutL1),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stbL1), .wb_cyc_i(cyc), .wb_ack_o(ackL1),
    .sram_adr(unusedAdrL1), .sram_dat(unusedSramL1), .sram_be_n(unusedBeL1), .sram_ce_n(ceL1),
    .sram_oe_n(unusedOeL1), .sram_we_n(unusedWeL1)
  );

  wb_sram32 #(.adr_width(18), .latency(15)) dutL15 (
    .clk(clk), .rst(rst), .wb_adr_i(wbAdr), .wb_dat_i(wbDat), .wb_dat_o(unusedDatOutL15),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stbL15), .wb_cyc_i(cyc), .wb_ack_o(ackL15),
    .sram_adr(unusedAdrL15), .sram_dat(unusedSramL15), .sram_be_n(unusedBeL15), .sram_ce_n(ceL15),
    .sram_oe_n(unusedOeL15), .sram_we_n(unusedWeL15)
  );

  // Asynchronous SRAM device: drives the bus while selected and output-enabled, stores enabled lanes mid-cycle.
  assign sramDat = (!ceN && !oeN) ? devMem[sramAdr] : {32{1'bz}};

  always @(negedge clk) begin
    if (!ceN && !weN) begin
      for (int i = 0; i < 4; i++) begin
        if (!beN[i]) devMem[sramAdr][8*i +: 8] <= sramDat[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] mergeLanes(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: strobes for LAT cycles, ack in cycle LAT+1, idle the cycle after.
  always @(posedge clk) begin
    if (rst) begin
      mBusy     <= 1'b0;
      mLastRead <= 32'd0;
      mChkEn    <= 1'b1;
    end else if (mBusy) begin
      mK <= mK + 1;
      if (mK == LAT && !mWe) mLastRead <= refMem[mAdr];
      if (mK == LAT + 1) mBusy <= 1'b0;
    end else if (cyc && stbMain) begin
      mBusy <= 1'b1;
      mK    <= 1;
      mWe   <= we;
      mSel  <= sel;
      mAdr  <= wbAdr[19:2];
      mWdat <= wbDat;
      if (we) refMem[wbAdr[19:2]] <= mergeLanes(refMem[wbAdr[19:2]], wbDat, sel);
    end
  end

  always @(negedge clk) begin
    if (mChkEn) begin
      bit strobe, ackExp;
      strobe = mBusy && (mK <= LAT);
      ackExp = mBusy && (mK == LAT + 1);
      checkOutput("ack", {31'd0, ack}, {31'd0, ackExp});
      checkOutput("ce_n", {31'd0, ceN}, {31'd0, !strobe});
      checkOutput("oe_n", {31'd0, oeN}, {31'd0, !(strobe && !mWe)});
      checkOutput("we_n", {31'd0, weN}, {31'd0, !(strobe && mWe)});
      checkOutput("be_n", {28'd0, beN}, {28'd0, strobe ? (mWe ? ~mSel : 4'h0) : 4'hF});
      checkOutput("wb_dat_o", datOut, mLastRead);
      if (strobe) checkOutput("sram_adr", {14'd0, sramAdr}, {14'd0, mAdr});
      if (mBusy && mWe) checkOutput("write data on bus", sramDat, mWdat);
    end
  end

  task automatic applyStimulus(input bit isWrite, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input bit dropEarly,
                               output logic [31:0] rdata, output int ackCyc, output int strb,
                               output logic [3:0] beSeen, output logic [17:0] adrSeen);
    @(negedge clk);
    #1;
    we = isWrite; wbAdr = a; wbDat = d; sel = s; cyc = 1'b1; stbMain = 1'b1;
    ackCyc = 0; strb = 0; rdata = 32'd0; beSeen = 4'hF; adrSeen = 18'd0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!ceN) begin
        if (strb == 0) begin beSeen = beN; adrSeen = sramAdr; end
        strb++;
      end
      if (ack) begin ackCyc = n; rdata = datOut; break; end
      if (dropEarly && n == 1) begin
        #1;
        cyc = 1'b0; stbMain = 1'b0; we = ~we; wbAdr = $urandom; wbDat = $urandom; sel = ~sel;
      end
    end
    if (ackCyc == 0) checkOutput("ack timeout", 32'd0, 32'd1);
    #1;
    cyc = 1'b0; stbMain = 1'b0;
  endtask

  task automatic measureSweep(input bit useL1, input bit isWrite, output int ackCyc, output int strb);
    @(negedge clk);
    #1;
    we = isWrite; wbAdr = 32'h4000_0008; wbDat = 32'h1234_5678; sel = 4'hF; cyc = 1'b1;
    if (useL1) stbL1 = 1'b1; else stbL15 = 1'b1;
    ackCyc = 0; strb = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (useL1 ? !ceL1 : !ceL15) strb++;
      if (useL1 ? ackL1 : ackL15) begin ackCyc = n; break; end
    end
    #1;
    cyc = 1'b0; stbL1 = 1'b0; stbL15 = 1'b0;
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ra;
    logic [31:0] expB2b [0:2];
    logic [3:0]  be;
    logic [17:0] ad;
    int          ac, sb, acks, runs, prevCe;

    rst = 1'b1; cyc = 1'b0; stbMain = 1'b0; stbL1 = 1'b0; stbL15 = 1'b0;
    we = 1'b0; wbAdr = 32'd0; wbDat = 32'd0; sel = 4'h0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset ack", {31'd0, ack}, 32'd0);
    checkOutput("reset ce_n", {31'd0, ceN}, 32'd1);
    checkOutput("reset be_n", {28'd0, beN}, 32'hF);
    checkOutput("reset wb_dat_o", datOut, 32'd0);

    $display("[TB] write then read, latency %0d", LAT);
    applyStimulus(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, ac, sb, be, ad);
    checkOutput("wr ack cycle", ac, 32'd3);
    checkOutput("wr strobe cycles", sb, 32'd2);
    checkOutput("wr sram_adr", {14'd0, ad}, 32'd4);
    applyStimulus(1'b0, 32'h4000_0010, 32'd0, 4'hF, 1'b0, rd, ac, sb, be, ad);
    checkOutput("rd data", rd, 32'hDEAD_BEEF);
    checkOutput("rd ack cycle", ac, 32'd3);
    checkOutput("rd strobe cycles", sb, 32'd2);

    $display("[TB] byte lanes");
    applyStimulus(1'b1, 32'h4000_0040, 32'h1122_3344, 4'hF, 1'b0, rd, ac, sb, be, ad);
    applyStimulus(1'b1, 32'h4000_0040, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, ac, sb, be, ad);
    checkOutput("lane be_n", {28'd0, be}, 32'hA);
    checkOutput("model lane merge", refMem[16], 32'h11BB_33DD);
    applyStimulus(1'b0, 32'h4000_0040, 32'd0, 4'hF, 1'b0, rd, ac, sb, be, ad);
    checkOutput("lane read", rd, 32'h11BB_33DD);

    $display("[TB] aliasing and sel=0");
    applyStimulus(1'b1, 32'h4010_0000, 32'h5A5A_1234, 4'hF, 1'b0, rd, ac, sb, be, ad);
    checkOutput("alias lands at word 0", devMem[0], 32'h5A5A_1234);
    applyStimulus(1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'h0, 1'b0, rd, ac, sb, be, ad);
    checkOutput("sel0 ack cycle", ac, 32'd3);
    checkOutput("sel0 be_n", {28'd0, be}, 32'hF);
    applyStimulus(1'b0, 32'h4000_0000, 32'd0, 4'hF, 1'b0, rd, ac, sb, be, ad);
    checkOutput("sel0 memory unchanged", rd, 32'h5A5A_1234);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 32'h4000_0004, 32'h0101_0101, 4'hF, 1'b0, rd, ac, sb, be, ad);
    applyStimulus(1'b1, 32'h4000_0008, 32'h0202_0202, 4'hF, 1'b0, rd, ac, sb, be, ad);
    expB2b[0] = 32'h5A5A_1234; expB2b[1] = 32'h0101_0101; expB2b[2] = 32'h0202_0202;
    @(negedge clk);
    #1;
    we = 1'b0; wbAdr = 32'h4000_0000; sel = 4'hF; cyc = 1'b1; stbMain = 1'b1;
    acks = 0; runs = 0; prevCe = 1;
    for (int n = 0; n < 60 && acks < 3; n++) begin
      @(negedge clk);
      if (!ceN && prevCe == 1) runs++;
      prevCe = int'(ceN);
      if (ack) begin
        checkOutput("b2b data", datOut, expB2b[acks]);
        acks++;
        #1;
        if (acks == 3) begin cyc = 1'b0; stbMain = 1'b0; end
        else wbAdr = wbAdr + 32'd4;
      end
    end
    cyc = 1'b0; stbMain = 1'b0;
    checkOutput("b2b ack count", acks, 32'd3);
    checkOutput("b2b separated strobe runs", runs, 32'd3);

    $display("[TB] random traffic");
    for (int t = 0; t < 150; t++) begin
      ra = ($urandom & 32'hFFF0_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom), ($urandom_range(0, 3) == 0),
                    rd, ac, sb, be, ad);
      checkOutput("rand ack cycle", ac, LAT + 1);
    end

    $display("[TB] reset during write");
    @(negedge clk);
    #1;
    we = 1'b1; wbAdr = 32'h4000_0020; wbDat = 32'hCAFE_F00D; sel = 4'hF; cyc = 1'b1; stbMain = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1; cyc = 1'b0; stbMain = 1'b0;
    @(negedge clk);
    checkOutput("abort ce_n", {31'd0, ceN}, 32'd1);
    checkOutput("abort we_n", {31'd0, weN}, 32'd1);
    checkOutput("abort ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'h4000_0020, 32'd0, 4'hF, 1'b0, rd, ac, sb, be, ad);
    checkOutput("read after abort ack cycle", ac, 32'd3);
    checkOutput("read after abort data", rd, 32'hCAFE_F00D);

    $display("[TB] latency sweep");
    measureSweep(1'b1, 1'b0, ac, sb);
    checkOutput("lat1 rd ack cycle", ac, 32'd2);
    checkOutput("lat1 rd strobes", sb, 32'd1);
    measureSweep(1'b1, 1'b1, ac, sb);
    checkOutput("lat1 wr ack cycle", ac, 32'd2);
    measureSweep(1'b0, 1'b0, ac, sb);
    checkOutput("lat15 rd ack cycle", ac, 32'd16);
    checkOutput("lat15 rd strobes", sb, 32'd15);
    measureSweep(1'b0, 1'b1, ac, sb);
    checkOutput("lat15 wr ack cycle", ac, 32'd16);
    checkOutput("lat15 wr strobes", sb, 32'd15);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
